// File: rtl/fabosc_reset_sequencer.sv
// ============================================================================
// Module   : fabosc_reset_sequencer
// Purpose  : Power-on reset sequencer on the fabric RC oscillator clock; staged
//            CCC -> fabric -> USB reset release gated by a filtered PLL lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fabosc_reset_sequencer #(
  parameter int STARTUP_CYCLES    = 1024,
  parameter int LOCK_FILTER       = 16,
  parameter int STAGE_GAP         = 8,
  parameter int SOFT_RESET_CYCLES = 32
) (
  input  logic       CLK_BASE,
  input  logic       POWER_ON_RESET_N,
  input  logic       PLL_LOCK,
  input  logic       SOFT_RESET_REQ,
  output logic       PLL_ARST_N,
  output logic       FAB_RESET_N,
  output logic       USB_RESET_N,
  output logic       READY,
  output logic       LOCK_LOST,
  output logic [2:0] STATE
);

  localparam int MAX_AB = (STARTUP_CYCLES > LOCK_FILTER) ? STARTUP_CYCLES : LOCK_FILTER;
  localparam int MAX_CD = (STAGE_GAP > SOFT_RESET_CYCLES) ? STAGE_GAP : SOFT_RESET_CYCLES;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P) + 1;

  // Terminal values: a count of N leaves the state on the N-th cycle in it.
  localparam logic [CW-1:0] SETTLE_LAST = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] FILTER_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] SOFT_LAST   = CW'(SOFT_RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_SETTLE    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_REL_FAB   = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sync_q, sync_d;
  logic          pll_arst_n_q, pll_arst_n_d;
  logic          fab_reset_n_q, fab_reset_n_d;
  logic          usb_reset_n_q, usb_reset_n_d;
  logic          ready_q, ready_d;
  logic          lock_lost_q, lock_lost_d;
  logic          lock_s;

  assign lock_s = sync_q[1];

  always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N) begin
      state_q       <= ST_SETTLE;
      cnt_q         <= '0;
      sync_q        <= '0;
      pll_arst_n_q  <= 1'b0;
      fab_reset_n_q <= 1'b0;
      usb_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync_q        <= sync_d;
      pll_arst_n_q  <= pll_arst_n_d;
      fab_reset_n_q <= fab_reset_n_d;
      usb_reset_n_q <= usb_reset_n_d;
      ready_q       <= ready_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  always_comb begin
    sync_d        = {sync_q[0], PLL_LOCK};
    state_d       = state_q;
    cnt_d         = cnt_q;
    pll_arst_n_d  = pll_arst_n_q;
    fab_reset_n_d = fab_reset_n_q;
    usb_reset_n_d = usb_reset_n_q;
    ready_d       = ready_q;
    lock_lost_d   = lock_lost_q;

    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d      = ST_WAIT_LOCK;
          cnt_d        = '0;
          pll_arst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == FILTER_LAST) begin
          state_d       = ST_REL_FAB;
          cnt_d         = '0;
          fab_reset_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_REL_FAB: begin
        if (!lock_s) begin
          state_d       = ST_WAIT_LOCK;
          cnt_d         = '0;
          fab_reset_n_d = 1'b0;
        end else if (cnt_q == GAP_LAST) begin
          state_d       = ST_RUN;
          cnt_d         = '0;
          usb_reset_n_d = 1'b1;
          ready_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RUN: begin
        // Lock loss outranks a coincident soft-reset request.
        if (!lock_s) begin
          state_d       = ST_WAIT_LOCK;
          cnt_d         = '0;
          fab_reset_n_d = 1'b0;
          usb_reset_n_d = 1'b0;
          ready_d       = 1'b0;
          lock_lost_d   = 1'b1;
        end else if (SOFT_RESET_REQ) begin
          state_d       = ST_SOFT;
          cnt_d         = '0;
          fab_reset_n_d = 1'b0;
          usb_reset_n_d = 1'b0;
          ready_d       = 1'b0;
        end
      end

      ST_SOFT: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SOFT_LAST) begin
          state_d       = ST_REL_FAB;
          cnt_d         = '0;
          fab_reset_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d       = ST_SETTLE;
        cnt_d         = '0;
        pll_arst_n_d  = 1'b0;
        fab_reset_n_d = 1'b0;
        usb_reset_n_d = 1'b0;
        ready_d       = 1'b0;
      end
    endcase
  end

  assign PLL_ARST_N  = pll_arst_n_q;
  assign FAB_RESET_N = fab_reset_n_q;
  assign USB_RESET_N = usb_reset_n_q;
  assign READY       = ready_q;
  assign LOCK_LOST   = lock_lost_q;
  assign STATE       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_fabosc_reset_sequencer.sv
// ============================================================================
// Module   : tb_fabosc_reset_sequencer
// Purpose  : Directed self-checking bench for fabosc_reset_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fabosc_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       soft_req;
  logic       pll_arst_n;
  logic       fab_reset_n;
  logic       usb_reset_n;
  logic       ready;
  logic       lock_lost;
  logic [2:0] state;

  // {PLL_ARST_N, FAB_RESET_N, USB_RESET_N, READY, LOCK_LOST, STATE[2:0]}
  logic [7:0] obs;
  assign obs = {pll_arst_n, fab_reset_n, usb_reset_n, ready, lock_lost, state};

  int tests_run;
  int tests_failed;
  int edge_n;

  fabosc_reset_sequencer #(
    .STARTUP_CYCLES   (16),
    .LOCK_FILTER      (4),
    .STAGE_GAP        (3),
    .SOFT_RESET_CYCLES(5)
  ) dut (
    .CLK_BASE        (clk),
    .POWER_ON_RESET_N(rst_n),
    .PLL_LOCK        (pll_lock),
    .SOFT_RESET_REQ  (soft_req),
    .PLL_ARST_N      (pll_arst_n),
    .FAB_RESET_N     (fab_reset_n),
    .USB_RESET_N     (usb_reset_n),
    .READY           (ready),
    .LOCK_LOST       (lock_lost),
    .STATE           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after rising edge k (counted from POR release).
  task automatic step_to(input int k);
    while (edge_n < k) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic por_release();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    soft_req = 1'b0;
    #3;
    tests_run++;
    if (obs !== 8'b0000_0000) begin
      tests_failed++;
      $display("FAIL reset_values: got %b want %b", obs, 8'b0000_0000);
    end
  endtask

  task automatic test_clean_powerup();
    pll_lock = 1'b1;
    por_release();
    step_to(15);
    tests_run++;
    if (obs !== 8'b0000_0000) begin tests_failed++; $display("FAIL clean_e15: got %b want %b", obs, 8'b0000_0000); end
    step_to(16);
    tests_run++;
    if (obs !== 8'b1000_0001) begin tests_failed++; $display("FAIL clean_e16: got %b want %b", obs, 8'b1000_0001); end
    step_to(19);
    tests_run++;
    if (obs !== 8'b1000_0001) begin tests_failed++; $display("FAIL clean_e19: got %b want %b", obs, 8'b1000_0001); end
    step_to(20);
    tests_run++;
    if (obs !== 8'b1100_0010) begin tests_failed++; $display("FAIL clean_e20: got %b want %b", obs, 8'b1100_0010); end
    step_to(22);
    tests_run++;
    if (obs !== 8'b1100_0010) begin tests_failed++; $display("FAIL clean_e22: got %b want %b", obs, 8'b1100_0010); end
    step_to(23);
    tests_run++;
    if (obs !== 8'b1111_0011) begin tests_failed++; $display("FAIL clean_e23: got %b want %b", obs, 8'b1111_0011); end
  endtask

  task automatic test_late_lock();
    pll_lock = 1'b0;
    por_release();
    step_to(24);
    soft_req = 1'b1;
    step_to(25);
    soft_req = 1'b0;
    tests_run++;
    if (obs !== 8'b1000_0001) begin tests_failed++; $display("FAIL soft_ignored_wait: got %b want %b", obs, 8'b1000_0001); end
    step_to(30);
    tests_run++;
    if (obs !== 8'b1000_0001) begin tests_failed++; $display("FAIL late_e30: got %b want %b", obs, 8'b1000_0001); end
    pll_lock = 1'b1;
    step_to(35);
    tests_run++;
    if (obs !== 8'b1000_0001) begin tests_failed++; $display("FAIL late_e35: got %b want %b", obs, 8'b1000_0001); end
    step_to(36);
    tests_run++;
    if (obs !== 8'b1100_0010) begin tests_failed++; $display("FAIL late_e36: got %b want %b", obs, 8'b1100_0010); end
    step_to(38);
    tests_run++;
    if (obs !== 8'b1100_0010) begin tests_failed++; $display("FAIL late_e38: got %b want %b", obs, 8'b1100_0010); end
    step_to(39);
    tests_run++;
    if (obs !== 8'b1111_0011) begin tests_failed++; $display("FAIL late_e39: got %b want %b", obs, 8'b1111_0011); end
  endtask

  task automatic test_lock_glitch();
    pll_lock = 1'b0;
    por_release();
    step_to(20);
    pll_lock = 1'b1;
    step_to(23);
    pll_lock = 1'b0;
    step_to(24);
    pll_lock = 1'b1;
    step_to(26);
    tests_run++;
    if (obs !== 8'b1000_0001) begin tests_failed++; $display("FAIL glitch_e26: got %b want %b", obs, 8'b1000_0001); end
    step_to(29);
    tests_run++;
    if (obs !== 8'b1000_0001) begin tests_failed++; $display("FAIL glitch_e29: got %b want %b", obs, 8'b1000_0001); end
    step_to(30);
    tests_run++;
    if (obs !== 8'b1100_0010) begin tests_failed++; $display("FAIL glitch_e30: got %b want %b", obs, 8'b1100_0010); end
  endtask

  task automatic test_lock_loss_relock();
    pll_lock = 1'b1;
    por_release();
    step_to(50);
    pll_lock = 1'b0;
    step_to(52);
    tests_run++;
    if (obs !== 8'b1111_0011) begin tests_failed++; $display("FAIL loss_e52: got %b want %b", obs, 8'b1111_0011); end
    step_to(53);
    tests_run++;
    if (obs !== 8'b1000_1001) begin tests_failed++; $display("FAIL loss_e53: got %b want %b", obs, 8'b1000_1001); end
    step_to(60);
    pll_lock = 1'b1;
    step_to(65);
    tests_run++;
    if (obs !== 8'b1000_1001) begin tests_failed++; $display("FAIL relock_e65: got %b want %b", obs, 8'b1000_1001); end
    step_to(66);
    tests_run++;
    if (obs !== 8'b1100_1010) begin tests_failed++; $display("FAIL relock_e66: got %b want %b", obs, 8'b1100_1010); end
    step_to(69);
    tests_run++;
    if (obs !== 8'b1111_1011) begin tests_failed++; $display("FAIL relock_e69: got %b want %b", obs, 8'b1111_1011); end
  endtask

  task automatic test_soft_reset();
    pll_lock = 1'b1;
    por_release();
    step_to(60);
    soft_req = 1'b1;
    step_to(61);
    soft_req = 1'b0;
    tests_run++;
    if (obs !== 8'b1000_0100) begin tests_failed++; $display("FAIL soft_e61: got %b want %b", obs, 8'b1000_0100); end
    step_to(65);
    tests_run++;
    if (obs !== 8'b1000_0100) begin tests_failed++; $display("FAIL soft_e65: got %b want %b", obs, 8'b1000_0100); end
    step_to(66);
    tests_run++;
    if (obs !== 8'b1100_0010) begin tests_failed++; $display("FAIL soft_e66: got %b want %b", obs, 8'b1100_0010); end
    step_to(68);
    tests_run++;
    if (obs !== 8'b1100_0010) begin tests_failed++; $display("FAIL soft_e68: got %b want %b", obs, 8'b1100_0010); end
    step_to(69);
    tests_run++;
    if (obs !== 8'b1111_0011) begin tests_failed++; $display("FAIL soft_e69: got %b want %b", obs, 8'b1111_0011); end
  endtask

  task automatic test_soft_vs_lock();
    pll_lock = 1'b1;
    por_release();
    step_to(58);
    pll_lock = 1'b0;
    step_to(60);
    tests_run++;
    if (obs !== 8'b1111_0011) begin tests_failed++; $display("FAIL prio_e60: got %b want %b", obs, 8'b1111_0011); end
    soft_req = 1'b1;
    step_to(61);
    soft_req = 1'b0;
    tests_run++;
    if (obs !== 8'b1000_1001) begin tests_failed++; $display("FAIL prio_e61: got %b want %b", obs, 8'b1000_1001); end
  endtask

  task automatic test_por_mid_settle();
    pll_lock = 1'b1;
    por_release();
    step_to(8);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs !== 8'b0000_0000) begin tests_failed++; $display("FAIL por_settle: got %b want %b", obs, 8'b0000_0000); end
    por_release();
    step_to(15);
    tests_run++;
    if (obs !== 8'b0000_0000) begin tests_failed++; $display("FAIL restart_e15: got %b want %b", obs, 8'b0000_0000); end
    step_to(16);
    tests_run++;
    if (obs !== 8'b1000_0001) begin tests_failed++; $display("FAIL restart_e16: got %b want %b", obs, 8'b1000_0001); end
  endtask

  // Entered from RUN with LOCK_LOST already set by the relock scenario.
  task automatic test_por_mid_run();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs !== 8'b0000_0000) begin tests_failed++; $display("FAIL por_run: got %b want %b", obs, 8'b0000_0000); end
    por_release();
    step_to(15);
    tests_run++;
    if (obs !== 8'b0000_0000) begin tests_failed++; $display("FAIL rerun_e15: got %b want %b", obs, 8'b0000_0000); end
    step_to(20);
    tests_run++;
    if (obs !== 8'b1100_0010) begin tests_failed++; $display("FAIL rerun_e20: got %b want %b", obs, 8'b1100_0010); end
    step_to(23);
    tests_run++;
    if (obs !== 8'b1111_0011) begin tests_failed++; $display("FAIL rerun_e23: got %b want %b", obs, 8'b1111_0011); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    edge_n       = 0;
    test_reset();
    test_clean_powerup();
    test_late_lock();
    test_lock_glitch();
    test_soft_reset();
    test_soft_vs_lock();
    test_por_mid_settle();
    test_lock_loss_relock();
    test_por_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
